dmem_responder: RTL

Data-memory responder for the RISC-V core's load/store port. It accepts one word-aligned request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte-strobed writes or registered reads on an internal word array and returns a single-cycle response pulse with an error flag. It takes the memory side of the core's data interface and replaces the zero-latency data memory when wait-state behaviour is exercised.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_ram_array.sv | 24 ++
 rtl/dmem_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and address decode for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {RAM, MMIO, BAD} region_t;

    localparam int WSTRB_W = 4;
    localparam int CNT_W   = 4;

    function automatic region_t decode(
        input logic [31:0] addr,
        input int          depth_words,
        input logic [31:0] mmio_base,
        input logic        mmio_en
    );
        if (addr[1:0] != 2'b00)                 return BAD;
        if (addr < 32'(4 * depth_words))        return RAM;
        if (mmio_en && addr == mmio_base)       return MMIO;
        return BAD;
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// dmem_ram_array: word array with byte-strobed synchronous write and combinational read, no reset.
module dmem_ram_array import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [31:0]        wdata,
    input  logic [WSTRB_W-1:0] wstrb,
    input  logic [AW-1:0]      raddr,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WSTRB_W; i++)
            if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with valid/ready request and one-cycle response.
// Define DMEM_MMIO_COUNTER_EN to add a read/writable free-running cycle counter at MMIO_BASE.
module dmem_responder import dmem_pkg::*; #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [WSTRB_W-1:0] req_wstrb,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               write_q;
    logic [31:0]        addr_q, wdata_q;
    logic [WSTRB_W-1:0] wstrb_q;
    logic               cur_write;
    logic [31:0]        cur_addr, cur_wdata;
    logic [WSTRB_W-1:0] cur_wstrb;
    region_t            region;
    logic               err, exec, ram_we;
    logic [31:0]        ram_rdata, mmio_rdata;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states execution happens on the accept edge, so use the live request.
    assign cur_write = (state == IDLE) ? req_write : write_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;

`ifdef DMEM_MMIO_COUNTER_EN
    localparam logic MMIO_EN = 1'b1;
    logic [31:0] cycles;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycles <= '0;
        else        cycles <= (exec && region == MMIO && cur_write && !err) ? cur_wdata : cycles + 32'd1;
    end
    assign mmio_rdata = cycles;
`else
    localparam logic MMIO_EN = 1'b0;
    assign mmio_rdata = '0;
`endif

    assign region    = decode(cur_addr, DEPTH_WORDS, MMIO_BASE, MMIO_EN);
    assign err       = region == BAD || (region == MMIO && cur_write && cur_wstrb != 4'hF);
    assign exec      = next_state == RESP && state != RESP;
    assign ram_we    = exec && cur_write && region == RAM && reset;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                cnt     <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (exec) begin
                rsp_err   <= err;
                rsp_rdata <= (err || cur_write) ? '0 : (region == MMIO ? mmio_rdata : ram_rdata);
            end
        end
    end

    dmem_ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .raddr (cur_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule
